// File: rtl/ring_node_controller.sv
// ring_node_controller: per-node controller for one stage of a circular ring.
// Each cycle it looks at the slot passing the node. A packet addressed to this
// node is retired into a one-entry RX holding register. A queued outgoing packet
// from the TX FIFO is injected into a free slot. A free slot is an empty slot or
// one that is retired in this same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   slot_addr/data/id/type current ring slot (type 3'b000 = empty)
//   overwrite, ow_*        replacement slot contents toward the ring stage
//                          (combinational, acts at the ring stage's next edge)
//   tx_valid/ready, tx_*   client -> node outgoing packet handshake
//   rx_valid/ready, rx_*   node -> client delivered packet handshake
//   tx_starve              FIFO head blocked for STARVE_LIMIT consecutive cycles
module ring_node_controller #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned NODE_ID      = 0,
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    // ring stage, current slot
    input  logic [35:0]       slot_addr,
    input  logic [DATA_W-1:0] slot_data,
    input  logic [3:0]        slot_id,
    input  logic [2:0]        slot_type,
    // ring stage, overwrite path
    output logic              overwrite,
    output logic [35:0]       ow_addr,
    output logic [DATA_W-1:0] ow_data,
    output logic [3:0]        ow_id,
    output logic [2:0]        ow_type,
    // client TX
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [35:0]       tx_addr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [3:0]        tx_id,
    input  logic [2:0]        tx_type,
    // client RX
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [35:0]       rx_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic [2:0]        rx_type,
    output logic              tx_starve
);

    localparam int unsigned ADDR_W = 36;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned PTR_W  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [TYPE_W-1:0] ptype;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLOCK = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    pkt_t              fifo_q [TX_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    state_e            state_q,  state_d;

    logic              rx_valid_q, rx_valid_d;
    logic [ADDR_W-1:0] rx_addr_q,  rx_addr_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic [TYPE_W-1:0] rx_type_q,  rx_type_d;

    // ------------------------------------------------------------------
    // Slot decision terms
    // ------------------------------------------------------------------
    logic fifo_empty, fifo_full;
    logic match, rx_space, consume, slot_free, inject;
    logic push, rx_pop;
    pkt_t head;

    assign fifo_empty = (count_q == CNT_W'(0));
    assign fifo_full  = (count_q == CNT_W'(TX_DEPTH));
    assign head       = fifo_q[rd_ptr_q];

    assign match     = (slot_type != TYPE_W'(0)) && (slot_id == ID_W'(NODE_ID));
    assign rx_space  = !rx_valid_q || rx_ready;
    // rst gates every action so reset cycles never move data
    assign consume   = !rst && match && rx_space;
    assign slot_free = (slot_type == TYPE_W'(0)) || consume;
    assign inject    = !rst && slot_free && !fifo_empty;

    assign tx_ready  = !rst && !fifo_full;
    // type 0 would look like an empty slot on the ring; accept and drop it
    assign push      = tx_valid && tx_ready && (tx_type != TYPE_W'(0));
    assign rx_pop    = rx_valid_q && rx_ready;

    // Overwrite path: head on inject, cleared slot on a bare consume
    always_comb begin
        overwrite = 1'b0;
        ow_addr   = '0;
        ow_data   = '0;
        ow_id     = '0;
        ow_type   = '0;
        if (inject) begin
            overwrite = 1'b1;
            ow_addr   = head.addr;
            ow_data   = head.data;
            ow_id     = head.id;
            ow_type   = head.ptype;
        end else if (consume) begin
            overwrite = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (inject) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, inject})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: tx_addr, data: tx_data, id: tx_id, ptype: tx_type};
        end
    end

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_addr_d  = rx_addr_q;
        rx_data_d  = rx_data_q;
        rx_type_d  = rx_type_q;
        if (consume) begin
            // covers pop-and-consume in the same cycle: new packet replaces old
            rx_valid_d = 1'b1;
            rx_addr_d  = slot_addr;
            rx_data_d  = slot_data;
            rx_type_d  = slot_type;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_addr_q  <= '0;
            rx_data_q  <= '0;
            rx_type_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_addr_q  <= rx_addr_d;
            rx_data_q  <= rx_data_d;
            rx_type_q  <= rx_type_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_addr  = rx_addr_q;
    assign rx_data  = rx_data_q;
    assign rx_type  = rx_type_q;

    // ------------------------------------------------------------------
    // Starvation counter: counts cycles the non-empty FIFO could not inject
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || inject) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // ------------------------------------------------------------------
    // Node state: IDLE when nothing is queued (RX occupancy does not block TX),
    // PEND when queued after a free slot, BLOCK when queued behind a busy slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (count_d == CNT_W'(0)) begin
            state_d = ST_IDLE;
        end else if (!slot_free) begin
            state_d = ST_BLOCK;
        end else begin
            state_d = ST_PEND;
        end
    end

    // A saturated counter implies the last slot was busy, so BLOCK qualifies it
    assign tx_starve = (starve_q == STV_W'(STARVE_LIMIT)) && (state_q == ST_BLOCK);

endmodule
